// File: rtl/servo_key_sequencer.sv
// Debounced two-button servo position stepper feeding the PWM scaler.
// New duty codes are committed only when the scaler's frame counter reads 0.
module servo_key_sequencer #(
    parameter int unsigned DEBOUNCE_TICKS = 500000,
    parameter logic [7:0]  CODE_MINUS90   = 8'd0,
    parameter logic [7:0]  CODE_CENTRE    = 8'd15,
    parameter logic [7:0]  CODE_PLUS90    = 8'd255
) (
    input  logic        d_in_clk,
    input  logic        d_reset,
    input  logic        d_enable,
    input  logic [1:0]  d_keys_n,
    input  logic [31:0] n_current_N_clks,
    output logic [7:0]  d_duty_cycle,
    output logic [1:0]  d_position,
    output logic        d_update
);

    localparam int CW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    // Enum values double as the d_position encoding.
    typedef enum logic [1:0] {
        NEG90  = 2'd0,
        CENTRE = 2'd1,
        POS90  = 2'd2
    } pos_t;

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;
    pos_t          target;
    pos_t          target_next;
    pos_t          applied;
    logic [7:0]    target_code;

    // Synchronise both keys, then require a stable differing level for
    // DEBOUNCE_TICKS consecutive clocks before accepting it.
    always_ff @(posedge d_in_clk) begin
        if (d_reset) begin
            s1    <= 2'b11;
            s2    <= 2'b11;
            deb   <= 2'b11;
            deb_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= d_keys_n;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press = deb_d & ~deb;

    always_ff @(posedge d_in_clk) begin
        if (d_reset) begin
            target <= CENTRE;
        end else begin
            target <= target_next;
        end
    end

    // Simultaneous presses cancel; steps saturate at either end.
    always_comb begin
        target_next = target;
        if (d_enable && (press[0] != press[1])) begin
            if (press[0]) begin
                case (target)
                    POS90:   target_next = CENTRE;
                    CENTRE:  target_next = NEG90;
                    default: target_next = NEG90;
                endcase
            end else begin
                case (target)
                    NEG90:   target_next = CENTRE;
                    CENTRE:  target_next = POS90;
                    default: target_next = POS90;
                endcase
            end
        end
    end

    always_comb begin
        target_code = CODE_CENTRE;
        case (target)
            NEG90:   target_code = CODE_MINUS90;
            POS90:   target_code = CODE_PLUS90;
            default: target_code = CODE_CENTRE;
        endcase
    end

    // Commit only at frame start so a pulse is never cut or stretched.
    always_ff @(posedge d_in_clk) begin
        if (d_reset) begin
            applied      <= CENTRE;
            d_duty_cycle <= CODE_CENTRE;
            d_position   <= 2'd1;
            d_update     <= 1'b0;
        end else begin
            d_update <= 1'b0;
            if ((n_current_N_clks == 32'd0) && (target != applied)) begin
                applied      <= target;
                d_duty_cycle <= target_code;
                d_position   <= target;
                d_update     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/servo_key_sequencer.md
# servo_key_sequencer

Upstream command stage for the servo PWM scaler: synchronises and debounces two raw push-buttons, steps a three-position servo target (-90 / centre / +90) and drives the 8-bit duty-cycle code the scaler decodes. The code is applied only at a PWM frame boundary, detected from the scaler's running clock count, so a position change never truncates or stretches a pulse mid-frame.

## Interface
- DEBOUNCE_TICKS, 500000, consecutive stable clocks required to accept a key level (10 ms at 50 MHz); minimum 2.
- CODE_MINUS90, 8'd0, duty code for -90.
- CODE_CENTRE, 8'd15, duty code for centre.
- CODE_PLUS90, 8'd255, duty code for +90.

- d_in_clk  in  1  clock, single clock domain.
- d_reset  in  1  synchronous, active-high reset.
- d_enable  in  1  when low, debounced press events are discarded, not queued.
- d_keys_n  in  2  raw active-low buttons, asynchronous; [0] = step toward -90, [1] = step toward +90.
- n_current_N_clks  in  32  scaler frame counter value; 0 marks frame start.
- d_duty_cycle  out  8  applied duty code to scaler, registered.
- d_position  out  2  applied position: 0 = -90, 1 = centre, 2 = +90; 3 never driven.
- d_update  out  1  one-cycle pulse on the cycle d_duty_cycle changes.

## Operation
- Per key: 2-flop synchroniser (s1, s2), then debouncer with level register deb and counter cnt (width ceil(log2(DEBOUNCE_TICKS))).
- Debouncer, each edge: if s2 == deb, cnt <= 0; else if cnt == DEBOUNCE_TICKS-1, deb <= s2 and cnt <= 0; else cnt <= cnt+1.
- Any return of s2 to deb before the count completes clears cnt. A glitch shorter than DEBOUNCE_TICKS produces no event.
- Press event = deb falls 1->0, detected against a one-cycle-delayed copy deb_d. The event is combinational, one cycle wide.
- Release is ignored. A held key produces exactly one event (no auto-repeat).
- Target FSM, states NEG90, CENTRE, POS90; reset state CENTRE.
  - Key0 event: POS90->CENTRE, CENTRE->NEG90, NEG90 stays (saturate).
  - Key1 event: NEG90->CENTRE, CENTRE->POS90, POS90 stays (saturate).
  - Both events in the same cycle: no transition.
  - d_enable = 0: events ignored. Debouncers keep running, so no stale event fires when enable returns.
- Commit: on an edge where n_current_N_clks == 0 and target != applied:
  - applied <= target;
  - d_duty_cycle <= code(target);
  - d_position <= encoding(target);
  - d_update <= 1.
- d_update is 0 on every other edge.
- Target changing again before commit: only the latest target is applied. Intermediate positions are skipped.
- n_current_N_clks held at 0 (scaler in reset): commit happens on the first edge target != applied.

## Timing
- Reset values:
  - s1, s2, deb, deb_d = 1 (released); cnt = 0.
  - target = applied = CENTRE.
  - d_duty_cycle = CODE_CENTRE; d_position = 1; d_update = 0.
- Reset mid-debounce or mid-pending commit: all progress discarded, pending target lost.
- A key physically held through reset is seen as a new press once debounced after reset.
- Latency: let edge 0 be the first edge sampling a new stable raw level.
  - deb changes at edge DEBOUNCE_TICKS+1.
  - Event is high during the following cycle.
  - Target updates at edge DEBOUNCE_TICKS+2.
- Target to output: commit at the first subsequent edge with n_current_N_clks == 0, minimum 1 clock. d_update is high for the cycle after that edge.
- d_duty_cycle is stable for whole frames, never changing while n_current_N_clks != 0.

## Test plan
(All scenarios use DEBOUNCE_TICKS = 4; the frame counter is modelled wrapping 0..99.)
1. Reset, no keys -> d_duty_cycle = 15, d_position = 1, d_update = 0 for 300 cycles.
2. Hold key1 low from edge 0, counter at 37 -> target POS90 at edge 6. d_duty_cycle stays 15 until the counter edge at 0, then 255, with one d_update pulse and d_position = 2. Holding longer gives no further change.
3. Key0 bounces low for 3 cycles, high 1, repeated 5 times -> no event, outputs unchanged. Then low for 10 cycles -> exactly one step.
4. From centre, two key1 presses inside one frame -> target saturates at POS90, single commit to 255. Then three key0 presses across frames -> commits 15, then 0, then no change (saturated).
5. Both keys pressed simultaneously (aligned edges) -> no transition, no d_update. With d_enable = 0, a key1 press gives no change; after d_enable returns to 1 and the key is held, still no change.
6. Assert d_reset while a target of POS90 is pending (counter nonzero) -> next cycle d_duty_cycle = 15, d_position = 1; no commit of 255 after the counter reaches 0. Key held through reset -> one press event DEBOUNCE_TICKS+2 edges after reset release.
